btn_conditioner: RTL



---
 rtl/btn_conditioner_pkg.sv | 21 ++
 rtl/btn_conditioner_channel.sv | 115 +++++++++++
 rtl/btn_conditioner.sv | 36 +++
 3 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing for the pushbutton conditioning stage.
package btn_conditioner_pkg;

   // Per-channel hold/repeat state.
   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      HOLD_DELAY  = 2'd1,
      HOLD_REPEAT = 2'd2
   } btn_state_e;

   // Defaults for a 50 MHz clock.
   localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
   localparam int DEF_REPEAT_RATE     = 5000000;   // 0.1 s

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debouncer and auto-repeat FSM.
module btn_channel
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int DW = cnt_w(DEBOUNCE_CYCLES);
   localparam int RW = cnt_w((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
   btn_state_e    state_q, state_d;
   logic          commit;

   // Next-state: synchroniser shift, debounce count/commit, hold/repeat FSM.
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      db_cnt_d  = '0;
      commit    = 1'b0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) commit = 1'b1;
         else                     db_cnt_d = db_cnt_q + 1'b1;
      end
      level_d   = commit ? ~level_q : level_q;
      press_d   = commit & ~level_q;
      release_d = commit & level_q;
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      // Repeat timer runs off the committed level only, so bounces that
      // never commit leave it untouched. A release always wins over a repeat.
      case (state_q)
         RELEASED: begin
            rpt_cnt_d = '0;
            if (press_d) state_d = HOLD_DELAY;
         end
         HOLD_DELAY: begin
            if (release_d) begin
               state_d   = RELEASED;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == DLY_LAST) begin
               // Without repeat enable the timer parks here until release.
               if (REPEAT_EN) begin
                  state_d   = HOLD_REPEAT;
                  rpt_cnt_d = '0;
                  press_d   = 1'b1;
               end
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
         HOLD_REPEAT: begin
            if (release_d) begin
               state_d   = RELEASED;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == RATE_LAST) begin
               press_d   = 1'b1;
               rpt_cnt_d = '0;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = RELEASED;
            rpt_cnt_d = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         rpt_cnt_q <= '0;
         state_q   <= RELEASED;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         rpt_cnt_q <= rpt_cnt_d;
         state_q   <= state_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw pushbuttons into debounced levels and press/release
// pulses; channels are independent and selected ones auto-repeat.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int               N_BTN           = 5,
   parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int               REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00110
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_pulse
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .btn_raw       (btn_raw[i]),
         .level         (level[i]),
         .press         (press[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule
